loop_down_counter: RTL

Loadable, cascadable down-counter with a small run/idle controller, used by the matrix-multiply sequencer for loop bounds (remaining rows, columns and accumulate steps).
- It is the borrow-chain counterpart of the team's carry-chain up-counter: it counts down from a loaded value and propagates a borrow to the next stage instead of a carry.
- When it exhausts, it reports completion with a one-cycle DONE pulse.

---
 rtl/mtx_pkg.sv | 15 +
 rtl/loop_down_counter_if.sv | 30 +++
 rtl/loop_down_counter.sv | 69 ++++++
 3 files changed

// File: rtl/mtx_pkg.sv
// Shared types and loop-counter widths for the matrix-multiply sequencer.
package mtx_pkg;

  // Run/idle controller state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default counter widths for the row, column and accumulate-step loops
  localparam int unsigned ROW_CNT_WIDTH  = 8;
  localparam int unsigned COL_CNT_WIDTH  = 8;
  localparam int unsigned STEP_CNT_WIDTH = 4;

endpackage : mtx_pkg

// File: rtl/loop_down_counter_if.sv
// Control/status bundle of one loop_down_counter stage.
interface loop_down_counter_if #(
  parameter int unsigned CNT_WIDTH = 4
);

  logic                 CE;
  logic                 B_IN;
  logic                 START;
  logic                 ABORT;
  logic                 AUTO_RELOAD;
  logic [CNT_WIDTH-1:0] LOAD_VAL;
  logic [CNT_WIDTH-1:0] RELOAD_VAL;
  logic                 B_OUT;
  logic [CNT_WIDTH-1:0] Q;
  logic                 BUSY;
  logic                 DONE;

  // Sequencer side: drives controls, observes count and status
  modport master (
    output CE, B_IN, START, ABORT, AUTO_RELOAD, LOAD_VAL, RELOAD_VAL,
    input  B_OUT, Q, BUSY, DONE
  );

  // Counter side
  modport slave (
    input  CE, B_IN, START, ABORT, AUTO_RELOAD, LOAD_VAL, RELOAD_VAL,
    output B_OUT, Q, BUSY, DONE
  );

endinterface : loop_down_counter_if

// File: rtl/loop_down_counter.sv
// Loadable, cascadable down-counter with run/idle control, borrow chain
// and a one-cycle DONE pulse on terminal count.
module loop_down_counter
  import mtx_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  loop_down_counter_if.slave  bus
);

  localparam int unsigned W = CNT_WIDTH;

  state_e         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic           done_q, done_d;
  logic           run_c;
  logic           zero_c;
  logic           dec_c;
  logic           term_c;

  assign run_c  = (state_q == RUN);
  assign zero_c = (q_q == '0);
  assign dec_c  = bus.CE & bus.B_IN & run_c;
  assign term_c = dec_c & zero_c;

  // Next-state, next-count and DONE; ABORT > START > term > dec
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (bus.ABORT) begin
      state_d = IDLE;
    end else if (bus.START) begin
      q_d     = bus.LOAD_VAL;
      state_d = RUN;
    end else if (term_c) begin
      done_d = 1'b1;
      if (bus.AUTO_RELOAD) begin
        q_d = bus.RELOAD_VAL;
      end else begin
        state_d = IDLE;
      end
    end else if (dec_c) begin
      q_d = q_q - W'(1);
    end
  end

  // Count, state and DONE registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  // Borrow out ignores CE so chained stages can share one enable
  assign bus.B_OUT = bus.B_IN & zero_c & run_c;
  assign bus.Q     = q_q;
  assign bus.BUSY  = run_c;
  assign bus.DONE  = done_q;

endmodule : loop_down_counter
